// File: rtl/cobs_pkg.sv
// Shared types and limits for the COBS framing path.
// Every block that feeds the byte-oriented COBS encoder imports this package.
package cobs_pkg;

  localparam int unsigned COBS_MAX_FRAME = 254;
  localparam int unsigned COBS_DW        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Header byte plus payload must fit into one encoder frame.
  function automatic bit cobs_len_ok(input int unsigned max_len, input int unsigned hdr_en);
    int unsigned hdr;
    hdr = (hdr_en != 0) ? 1 : 0;
    return (max_len >= 1) && ((max_len + hdr) <= COBS_MAX_FRAME);
  endfunction

  function automatic int unsigned cobs_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request after ptr_i, wrapping modulo N.
module rr_pick
  import cobs_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = cobs_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          hit_o,
  output logic [PW-1:0] idx_o
);

  logic [PW:0]  sh;
  logic [N-1:0] rot;
  int           first;

  // Rotate so ptr+1 lands on bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    sh    = (PW+1)'(ptr_i) + (PW+1)'(1);
    rot   = N'({req_i, req_i} >> sh);
    hit_o = |rot;
    first = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
    idx_o = PW'((int'(sh) + first) % int'(N));
  end

endmodule

// File: rtl/cobs_frame_arbiter.sv
// Packet-granular round-robin arbiter sharing one COBS encoder between N_SRC
// byte streams; adds an optional source-ID header and truncates over-long packets.
module cobs_frame_arbiter
  import cobs_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned HEADER_EN = 1,
  parameter int unsigned MAX_LEN   = 253
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC*DW-1:0] s_data,
  input  logic [N_SRC-1:0]    s_valid,
  output logic [N_SRC-1:0]    s_ready,
  input  logic [N_SRC-1:0]    s_last,
  output logic [DW-1:0]       m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic [N_SRC-1:0]    o_grant,
  output logic [N_SRC-1:0]    o_trunc
);

  localparam int unsigned GW = cobs_idx_w(N_SRC);
  localparam int unsigned CW = 8;

  if (!cobs_len_ok(MAX_LEN, HEADER_EN)) begin : g_len_chk
    $error("cobs_frame_arbiter: MAX_LEN plus header exceeds the encoder frame limit");
  end
  if (DW != COBS_DW) begin : g_dw_chk
    $error("cobs_frame_arbiter: DW must match the byte-oriented encoder");
  end

  state_t           state_q, state_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [N_SRC-1:0] trunc_q, trunc_d;

  logic             pick_hit;
  logic [GW-1:0]    pick_idx;
  logic [DW-1:0]    src_data [N_SRC];
  logic             at_cap;
  logic             hs;

  for (genvar i = 0; i < int'(N_SRC); i++) begin : g_src
    assign src_data[i] = s_data[i*DW +: DW];
  end

  rr_pick #(
    .N  (N_SRC),
    .PW (GW)
  ) u_pick (
    .req_i (s_valid),
    .ptr_i (ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  assign at_cap  = (cnt_q == CW'(MAX_LEN - 1));
  assign hs      = s_valid[gnt_q] & m_ready;
  assign o_grant = grant_q;
  assign o_trunc = trunc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= GW'(N_SRC - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      trunc_q <= trunc_d;
    end
  end

  // Next state plus the combinational byte path between owner and encoder.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    s_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          gnt_d   = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = (HEADER_EN != 0) ? HEADER : PAYLOAD;
        end
      end
      HEADER: begin
        m_valid = 1'b1;
        m_data  = DW'(gnt_q);
        if (m_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        m_valid        = s_valid[gnt_q];
        m_data         = src_data[gnt_q];
        m_last         = s_last[gnt_q] | at_cap;
        s_ready[gnt_q] = m_ready;
        if (hs) begin
          if (!at_cap) cnt_d = cnt_q + CW'(1);
          if (m_last) begin
            if (s_last[gnt_q]) begin
              state_d = IDLE;
            end else begin
              trunc_d[gnt_q] = 1'b1;
              state_d        = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        s_ready[gnt_q] = 1'b1;
        if (s_valid[gnt_q] && s_last[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    if (state_d != IDLE) grant_d = N_SRC'(1) << gnt_d;
  end

endmodule

// File: tb/tb_cobs_frame_arbiter.sv
// Randomized bench for cobs_frame_arbiter against a frame-level reference model.
module tb_cobs_frame_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 253;

  logic         clk;
  logic         rst;
  logic [31:0]  s_data;
  logic [3:0]   s_valid, s_ready, s_last;
  logic [7:0]   m_data;
  logic         m_valid, m_ready, m_last;
  logic [3:0]   o_grant, o_trunc;

  cobs_frame_arbiter #(
    .N_SRC(4), .DW(8), .HEADER_EN(1), .MAX_LEN(253)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .o_grant(o_grant), .o_trunc(o_trunc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source-side packet store and per-source valid hold.
  logic [7:0] src_q [N][$];
  bit         src_l [N][$];
  bit         hold  [N];

  // Reference model: who owns the encoder and how far through the frame we are.
  int         owner, phase, pos, fsize, ptr;
  bit         ftrunc;
  logic [3:0] trunc_exp;

  int         checks, errors;
  int         mr_mode, pat_idx;
  bit         bubble_en;
  logic [7:0] mon_q [$];
  int         hdr_q [$];
  bit         frame_start;
  int         flen, last_len, trunc_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int src, input logic [7:0] b, input bit last);
    src_q[src].push_back(b);
    src_l[src].push_back(last);
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int k = 0; k < len; k++) push_byte(src, 8'($urandom), k == len - 1);
  endtask

  task automatic pop_src(input int src, output bit last);
    last = src_l[src].pop_front();
    void'(src_q[src].pop_front());
    hold[src] = 1'b0;
  endtask

  task automatic model_reset();
    owner = -1; phase = 0; pos = 0; fsize = 0; ptr = N - 1;
    ftrunc = 1'b0; trunc_exp = '0; frame_start = 1'b1; flen = 0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      src_l[i].delete();
      hold[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_trunc", 32'(o_trunc), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle();
    logic [3:0] sv;
    logic [3:0] exp_grant;
    bit         l;
    bit         found;
    int         len;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && src_q[i].size() > 0 && (!bubble_en || $urandom_range(3, 0) != 0))
        hold[i] = 1'b1;
      s_valid[i] = hold[i];
      if (hold[i]) begin
        s_data[i*8 +: 8] = src_q[i][0];
        s_last[i]        = src_l[i][0];
      end else begin
        s_data[i*8 +: 8] = 8'($urandom);
        s_last[i]        = 1'($urandom);
      end
    end
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(3, 0) != 0);
      default: begin
        m_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end
    endcase
    sv = s_valid;
    #1;
    exp_grant = (owner >= 0) ? 4'(1 << owner) : 4'd0;
    chk("grant", 32'(o_grant), 32'(exp_grant));
    chk("trunc", 32'(o_trunc), 32'(trunc_exp));
    case (phase)
      0: begin
        chk("idle_mvalid", 32'(m_valid), 32'd0);
        chk("idle_sready", 32'(s_ready), 32'd0);
      end
      1: begin
        if (pos == 0) begin
          chk("hdr_mvalid", 32'(m_valid), 32'd1);
          chk("hdr_mdata", 32'(m_data), 32'(owner));
          chk("hdr_mlast", 32'(m_last), 32'd0);
          chk("hdr_sready", 32'(s_ready), 32'd0);
        end else begin
          chk("pay_mvalid", 32'(m_valid), 32'(sv[owner]));
          chk("pay_sready", 32'(s_ready), m_ready ? 32'(1 << owner) : 32'd0);
          if (sv[owner]) begin
            chk("pay_mdata", 32'(m_data), 32'(src_q[owner][0]));
            chk("pay_mlast", 32'(m_last), 32'(pos == fsize - 1));
          end
        end
      end
      default: begin
        chk("drain_mvalid", 32'(m_valid), 32'd0);
        chk("drain_sready", 32'(s_ready), 32'(1 << owner));
      end
    endcase
    if (m_valid && m_ready) begin
      mon_q.push_back(m_data);
      if (frame_start) begin
        hdr_q.push_back(int'(m_data));
        frame_start = 1'b0;
        flen = 0;
      end
      flen++;
      if (m_last) begin
        frame_start = 1'b1;
        last_len = flen;
      end
    end
    if (o_trunc != '0) trunc_seen++;
    trunc_exp = '0;
    case (phase)
      0: begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && sv[(ptr + k) % N]) begin
            found = 1'b1;
            owner = (ptr + k) % N;
          end
        end
        if (found) begin
          len = 0;
          for (int j = 0; j < src_l[owner].size(); j++)
            if (len == 0 && src_l[owner][j]) len = j + 1;
          ftrunc = (len > MAXL);
          fsize  = 1 + (ftrunc ? MAXL : len);
          ptr    = owner;
          pos    = 0;
          phase  = 1;
        end
      end
      1: begin
        if (pos == 0) begin
          if (m_ready) pos = 1;
        end else if (sv[owner] && m_ready) begin
          pop_src(owner, l);
          pos++;
          if (pos == fsize) begin
            if (ftrunc) begin
              phase = 2;
              trunc_exp = 4'(1 << owner);
            end else begin
              phase = 0;
              owner = -1;
            end
          end
        end
      end
      default: begin
        if (sv[owner]) begin
          pop_src(owner, l);
          if (l) begin
            phase = 0;
            owner = -1;
          end
        end
      end
    endcase
  endtask

  function automatic bit all_done();
    bit d;
    d = (phase == 0) && (trunc_exp == '0);
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    chk("run_timeout", 32'(all_done()), 32'd1);
    cycle();
  endtask

  logic [7:0] exp_a [4];
  int         exp_b [6];
  int         exp_g [4];
  logic [7:0] e_bytes [4];
  int         n;

  initial begin
    checks = 0; errors = 0; mr_mode = 0; pat_idx = 0; bubble_en = 1'b0;
    last_len = 0; trunc_seen = 0;
    s_data = '0;
    do_reset();

    // Single 3-byte packet from source 0.
    exp_a = '{8'h00, 8'h01, 8'h02, 8'h03};
    mon_q.delete();
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b0); push_byte(0, 8'h03, 1'b1);
    run_idle(50);
    chk("a_len", 32'(mon_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("a_byte", 32'(mon_q[k]), 32'(exp_a[k]));
    chk("a_flen", 32'(last_len), 32'd4);

    // Three contending sources, two packets each: strict round-robin order.
    do_reset();
    exp_b = '{0, 1, 2, 0, 1, 2};
    hdr_q.delete();
    for (int r = 0; r < 2; r++) for (int s = 0; s < 3; s++) add_pkt(s, 2);
    run_idle(200);
    chk("b_frames", 32'(hdr_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk("b_order", 32'(hdr_q[k]), 32'(exp_b[k]));

    // 300-byte packet on source 3 is cut at MAX_LEN and the tail drained.
    bubble_en = 1'b1; mr_mode = 1; trunc_seen = 0;
    add_pkt(3, 300);
    run_idle(3000);
    chk("c_trunc_pulses", 32'(trunc_seen), 32'd1);
    chk("c_flen", 32'(last_len), 32'(MAXL + 1));

    // Exactly MAX_LEN bytes is a normal frame.
    trunc_seen = 0;
    add_pkt(1, MAXL);
    run_idle(3000);
    chk("d_trunc_pulses", 32'(trunc_seen), 32'd0);
    chk("d_flen", 32'(last_len), 32'(MAXL + 1));

    // Ready pattern 1,0,0,1 over a 4-byte packet.
    bubble_en = 1'b0; mr_mode = 2; pat_idx = 0;
    mon_q.delete();
    e_bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    for (int k = 0; k < 4; k++) push_byte(2, e_bytes[k], k == 3);
    run_idle(100);
    chk("e_len", 32'(mon_q.size()), 32'd5);
    chk("e_hdr", 32'(mon_q[0]), 32'd2);
    for (int k = 0; k < 4; k++) chk("e_byte", 32'(mon_q[k + 1]), 32'(e_bytes[k]));

    // Random traffic mix with occasional over-long packets.
    bubble_en = 1'b1; mr_mode = 1;
    for (int p = 0; p < 30; p++) begin
      int src;
      int len;
      src = $urandom_range(3, 0);
      len = ($urandom_range(9, 0) == 0) ? $urandom_range(258, 254) : $urandom_range(12, 1);
      add_pkt(src, len);
    end
    run_idle(20000);

    // Asynchronous reset in the middle of a payload.
    bubble_en = 1'b0; mr_mode = 0;
    add_pkt(2, 20);
    n = 0;
    while (!(phase == 1 && pos >= 3) && n < 100) begin
      cycle();
      n++;
    end
    chk("g_reach_payload", 32'(phase == 1 && pos >= 3), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("g_async_grant", 32'(o_grant), 32'd0);
    chk("g_async_mvalid", 32'(m_valid), 32'd0);
    s_valid = '0; s_last = '0; m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_g = '{0, 1, 2, 3};
    hdr_q.delete();
    for (int s = 3; s >= 0; s--) add_pkt(s, 1);
    run_idle(100);
    chk("g_frames", 32'(hdr_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("g_order", 32'(hdr_q[k]), 32'(exp_g[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
